// File: rtl/glb_bank_sram_ctrl.sv
// Initiator side of the GLB bank SRAM port: arbitrates write and read-request streams onto
// the single active-low macro port and returns read data through a credit-protected FIFO.
module glb_bank_sram_ctrl #(
  parameter int DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH      = 14,
  parameter int SRAM_RD_LATENCY = 2,
  parameter int RD_FIFO_DEPTH   = 4
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 wr_valid,
  output logic                                 wr_ready,
  input  logic [ADDR_WIDTH-1:0]                wr_addr,
  input  logic [DATA_WIDTH-1:0]                wr_data,
  input  logic [DATA_WIDTH/8-1:0]              wr_strb,
  input  logic                                 rd_req_valid,
  output logic                                 rd_req_ready,
  input  logic [ADDR_WIDTH-1:0]                rd_req_addr,
  output logic                                 rd_resp_valid,
  input  logic                                 rd_resp_ready,
  output logic [DATA_WIDTH-1:0]                rd_resp_data,
  output logic                                 sram_ceb,
  output logic                                 sram_web,
  output logic [DATA_WIDTH-1:0]                sram_bweb,
  output logic [ADDR_WIDTH-1:0]                sram_a,
  output logic [DATA_WIDTH-1:0]                sram_d,
  input  logic [DATA_WIDTH-1:0]                sram_q,
  output logic                                 dbg_last_grant,
  output logic [$clog2(RD_FIFO_DEPTH+1)-1:0]   dbg_credit
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int PTR_W  = $clog2(RD_FIFO_DEPTH);
  localparam int CRED_W = $clog2(RD_FIFO_DEPTH + 1);
  localparam logic [PTR_W:0]    PTR_ONE  = 1;
  localparam logic [CRED_W-1:0] CRED_ONE = 1;
  localparam logic [CRED_W-1:0] CRED_RST = CRED_W'(RD_FIFO_DEPTH);

  // Handshake: a transfer happens on a rising clk edge where valid && ready.
  // Readys depend only on the valids, credits and last_grant, never the reverse.
  typedef enum logic {GRANT_WR = 1'b0, GRANT_RD = 1'b1} grant_e;

  grant_e                    last_q, last_d;
  logic                      grant_wr, grant_rd, rd_eligible;
  logic [CRED_W-1:0]         credit_q;
  logic [DATA_WIDTH-1:0]     wr_bweb;
  logic [SRAM_RD_LATENCY-1:0] rd_pipe_q;
  logic [DATA_WIDTH-1:0]     fifo_mem [RD_FIFO_DEPTH];
  logic [PTR_W:0]            wptr_q, rptr_q;
  logic                      fifo_empty, fifo_full, fifo_push, fifo_pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_q <= GRANT_WR;
    else          last_q <= last_d;
  end

  always_comb begin
    grant_wr    = 1'b0;
    grant_rd    = 1'b0;
    last_d      = last_q;
    rd_eligible = rd_req_valid && (credit_q != '0);
    if (reset_n) begin
      if (wr_valid && rd_eligible) begin
        if (last_q == GRANT_WR) grant_rd = 1'b1;
        else                    grant_wr = 1'b1;
      end else if (wr_valid) begin
        grant_wr = 1'b1;
      end else if (rd_eligible) begin
        grant_rd = 1'b1;
      end
    end
    if (grant_wr)      last_d = GRANT_WR;
    else if (grant_rd) last_d = GRANT_RD;
  end

  assign wr_ready       = grant_wr;
  assign rd_req_ready   = grant_rd;
  assign dbg_last_grant = last_q;
  assign dbg_credit     = credit_q;

  always_comb begin
    wr_bweb = '1;
    for (int b = 0; b < STRB_W; b++) wr_bweb[8*b +: 8] = {8{~wr_strb[b]}};
  end

  // A write with no enabled bytes is accepted but never reaches the macro.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sram_ceb  <= 1'b1;
      sram_web  <= 1'b1;
      sram_bweb <= '1;
      sram_a    <= '0;
      sram_d    <= '0;
    end else if (grant_wr && (wr_strb != '0)) begin
      sram_ceb  <= 1'b0;
      sram_web  <= 1'b0;
      sram_bweb <= wr_bweb;
      sram_a    <= wr_addr;
      sram_d    <= wr_data;
    end else if (grant_rd) begin
      sram_ceb  <= 1'b0;
      sram_web  <= 1'b1;
      sram_bweb <= '1;
      sram_a    <= rd_req_addr;
    end else begin
      sram_ceb  <= 1'b1;
      sram_web  <= 1'b1;
      sram_bweb <= '1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pipe_q <= '0;
    end else begin
      rd_pipe_q[0] <= grant_rd;
      for (int i = 1; i < SRAM_RD_LATENCY; i++) rd_pipe_q[i] <= rd_pipe_q[i-1];
    end
  end

  assign fifo_push     = rd_pipe_q[SRAM_RD_LATENCY-1];
  assign fifo_empty    = (wptr_q == rptr_q);
  assign fifo_full     = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                         (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
  assign rd_resp_valid = !fifo_empty;
  assign fifo_pop      = rd_resp_valid && rd_resp_ready;
  assign rd_resp_data  = fifo_mem[rptr_q[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wptr_q[PTR_W-1:0]] <= sram_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (fifo_push) wptr_q <= wptr_q + PTR_ONE;
      if (fifo_pop)  rptr_q <= rptr_q + PTR_ONE;
    end
  end

  // Credits cover FIFO slots plus reads still in the macro pipe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  credit_q <= CRED_RST;
    else if (grant_rd && !fifo_pop) credit_q <= credit_q - CRED_ONE;
    else if (!grant_rd && fifo_pop) credit_q <= credit_q + CRED_ONE;
  end

  a_no_fifo_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_glb_bank_sram_ctrl.sv
// Directed bench for glb_bank_sram_ctrl: a transaction-level model (memory array, response
// queue, credit = depth minus outstanding reads) is compared against the DUT every cycle.
module tb_glb_bank_sram_ctrl;

  localparam int DW    = 64;
  localparam int AW    = 14;
  localparam int SW    = DW / 8;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic          clk, reset_n;
  logic          wr_valid, wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [SW-1:0] wr_strb;
  logic          rd_req_valid, rd_req_ready;
  logic [AW-1:0] rd_req_addr;
  logic          rd_resp_valid, rd_resp_ready;
  logic [DW-1:0] rd_resp_data;
  logic          sram_ceb, sram_web;
  logic [DW-1:0] sram_bweb, sram_d, sram_q;
  logic [AW-1:0] sram_a;
  logic          dbg_last_grant;
  logic [2:0]    dbg_credit;

  glb_bank_sram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SRAM_RD_LATENCY(LAT),
                       .RD_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_strb(wr_strb),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready), .rd_resp_data(rd_resp_data),
    .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_bweb(sram_bweb), .sram_a(sram_a),
    .sram_d(sram_d), .sram_q(sram_q),
    .dbg_last_grant(dbg_last_grant), .dbg_credit(dbg_credit)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- SRAM macro environment (2-cycle read latency) ----------------
  logic [DW-1:0] sram_mem [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++) sram_mem[i] = '0;
    sram_q = '0;
  end
  always @(posedge clk) begin
    if (!sram_ceb) begin
      if (!sram_web) sram_mem[sram_a] <= (sram_mem[sram_a] & sram_bweb) | (sram_d & ~sram_bweb);
      else           sram_q <= sram_mem[sram_a];
    end
  end

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- scoreboard / model ----------------
  logic [DW-1:0] model_mem [0:(1<<AW)-1];
  logic [DW-1:0] exp_q [$];
  int            gcyc_q [$];
  logic          m_last_rd;
  logic          exp_ceb, exp_web;
  logic [AW-1:0] exp_a;
  logic [DW-1:0] exp_d, exp_bweb;
  logic          w_el, r_el, exp_w, exp_r, exp_rv;

  initial begin
    for (int i = 0; i < (1 << AW); i++) model_mem[i] = '0;
    m_last_rd = 1'b0;
    exp_ceb   = 1'b1;
    exp_web   = 1'b1;
    exp_a     = '0;
    exp_d     = '0;
    exp_bweb  = '1;
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_ceb", sram_ceb, 1);
      chk("rst_web", sram_web, 1);
      chk("rst_bweb", sram_bweb, {DW{1'b1}});
      chk("rst_a", sram_a, 0);
      chk("rst_d", sram_d, 0);
      chk("rst_resp_valid", rd_resp_valid, 0);
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_rd_req_ready", rd_req_ready, 0);
      exp_q.delete();
      gcyc_q.delete();
      m_last_rd = 1'b0;
      exp_ceb   = 1'b1;
    end else begin
      w_el = wr_valid;
      r_el = rd_req_valid && (exp_q.size() < DEPTH);
      if (w_el && r_el) begin
        exp_w = m_last_rd;
        exp_r = !m_last_rd;
      end else begin
        exp_w = w_el;
        exp_r = r_el;
      end
      chk("wr_ready", wr_ready, exp_w);
      chk("rd_req_ready", rd_req_ready, exp_r);
      chk("credit", dbg_credit, DEPTH - exp_q.size());
      chk("sram_ceb", sram_ceb, exp_ceb);
      if (!exp_ceb) begin
        chk("sram_web", sram_web, exp_web);
        chk("sram_a", sram_a, exp_a);
        chk("sram_bweb", sram_bweb, exp_bweb);
        if (!exp_web) chk("sram_d", sram_d, exp_d);
      end
      exp_rv = (exp_q.size() > 0) ? (cyc >= gcyc_q[0] + 1 + LAT) : 1'b0;
      chk("rd_resp_valid", rd_resp_valid, exp_rv);
      if (rd_resp_valid && rd_resp_ready && exp_q.size() > 0) begin
        chk("rd_resp_data", rd_resp_data, exp_q.pop_front());
        void'(gcyc_q.pop_front());
      end
      // Predict next-cycle pins and update the transaction model.
      exp_ceb = 1'b1;
      exp_web = 1'b1;
      if (exp_w) begin
        m_last_rd = 1'b0;
        if (wr_strb != '0) begin
          exp_ceb  = 1'b0;
          exp_web  = 1'b0;
          exp_a    = wr_addr;
          exp_d    = wr_data;
          exp_bweb = '1;
          for (int b = 0; b < SW; b++) begin
            if (wr_strb[b]) begin
              exp_bweb[8*b +: 8]         = 8'h00;
              model_mem[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
            end
          end
        end
      end else if (exp_r) begin
        m_last_rd = 1'b1;
        exp_ceb   = 1'b0;
        exp_web   = 1'b1;
        exp_a     = rd_req_addr;
        exp_bweb  = '1;
        exp_q.push_back(model_mem[rd_req_addr]);
        gcyc_q.push_back(cyc);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_valid     = 1'b0;
    rd_req_valid = 1'b0;
    wr_strb      = '0;
  endtask

  int  g, grants, prev_side, side, nw, nr;
  logic found, resumed, seen;

  initial begin
    reset_n       = 1'b0;
    wr_valid      = 1'b0;
    wr_addr       = '0;
    wr_data       = '0;
    wr_strb       = '0;
    rd_req_valid  = 1'b0;
    rd_req_addr   = '0;
    rd_resp_ready = 1'b1;

    // Reset held three cycles with random inputs.
    repeat (3) begin
      step();
      wr_valid      = 1'($urandom_range(0, 1));
      rd_req_valid  = 1'($urandom_range(0, 1));
      rd_resp_ready = 1'($urandom_range(0, 1));
      wr_addr       = AW'($urandom_range(0, (1 << AW) - 1));
      rd_req_addr   = AW'($urandom_range(0, (1 << AW) - 1));
      wr_data       = {$urandom, $urandom};
      wr_strb       = SW'($urandom_range(0, 255));
    end
    step();
    idle_inputs();
    rd_resp_ready = 1'b1;
    reset_n       = 1'b1;
    repeat (2) step();

    // Partial-strobe write then read of the same word.
    wr_valid = 1'b1; wr_addr = 14'h123; wr_data = 64'hDEADBEEF_CAFEF00D; wr_strb = 8'h0F;
    @(negedge clk);
    chk("t2_wr_ready", wr_ready, 1);
    step();
    wr_valid = 1'b0; wr_strb = '0;
    rd_req_valid = 1'b1; rd_req_addr = 14'h123;
    @(negedge clk);
    chk("t2_wr_bweb", sram_bweb, 64'hFFFFFFFF_00000000);
    chk("t2_rd_req_ready", rd_req_ready, 1);
    g = cyc;
    step();
    rd_req_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (rd_resp_valid) begin
        found = 1'b1;
        chk("t2_rd_latency", 64'(cyc - g), 3);
        chk("t2_rd_data", rd_resp_data, 64'h00000000_CAFEF00D);
      end
    end
    if (!found) chk("t2_rd_timeout", 0, 1);
    repeat (3) step();

    // Both streams valid for 20 cycles: grants must alternate starting with the write.
    nw = 0; nr = 0;
    wr_valid = 1'b1; wr_addr = 14'h40; wr_data = {$urandom, $urandom};
    wr_strb = SW'($urandom_range(1, 255));
    rd_req_valid = 1'b1; rd_req_addr = 14'h40;
    prev_side = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      side = wr_ready ? 0 : (rd_req_ready ? 1 : 2);
      if (i == 0) chk("t3_first_is_write", 64'(side), 0);
      else        chk("t3_alternate", 64'(side), (prev_side == 0) ? 1 : 0);
      prev_side = side;
      step();
      if (side == 0) begin
        nw++;
        wr_addr = AW'(14'h40 + (nw % 4));
        wr_data = {$urandom, $urandom};
        wr_strb = SW'($urandom_range(1, 255));
      end else if (side == 1) begin
        nr++;
        rd_req_addr = AW'(14'h40 + (nr % 4));
      end
    end
    idle_inputs();
    repeat (8) step();

    // Consumer stalled: only DEPTH reads may be granted.
    rd_resp_ready = 1'b0;
    rd_req_valid  = 1'b1;
    rd_req_addr   = 14'h40;
    grants = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      found = rd_req_ready;
      if (found) grants++;
      step();
      if (found) rd_req_addr = rd_req_addr + 14'd1;
    end
    chk("t4_grants_stalled", 64'(grants), 4);
    rd_resp_ready = 1'b1;
    resumed = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      found = rd_req_ready;
      if (found) resumed = 1'b1;
      step();
      if (found) rd_req_addr = rd_req_addr + 14'd1;
    end
    chk("t4_reads_resumed", 64'(resumed), 1);
    idle_inputs();
    repeat (10) step();

    // Write with no byte enables is accepted and dropped.
    wr_valid = 1'b1; wr_addr = 14'h200; wr_data = 64'h1111_2222_3333_4444; wr_strb = '0;
    @(negedge clk);
    chk("t5_wr_ready", wr_ready, 1);
    step();
    wr_valid = 1'b0;
    @(negedge clk);
    chk("t5_ceb_dropped", sram_ceb, 1);
    repeat (2) step();

    // Reset with two reads in flight: nothing may come back.
    rd_req_valid = 1'b1; rd_req_addr = 14'h40;
    @(negedge clk);
    chk("t6_rd0_ready", rd_req_ready, 1);
    step();
    rd_req_addr = 14'h41;
    @(negedge clk);
    chk("t6_rd1_ready", rd_req_ready, 1);
    step();
    rd_req_valid = 1'b0;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rd_resp_valid) seen = 1'b1;
    end
    chk("t6_no_resp_after_reset", 64'(seen), 0);
    chk("t6_credit_restored", dbg_credit, DEPTH);

    repeat (2) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
